// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: recovers the phase (16-bit binary angle)
// and gain-scaled magnitude of a signed (I, Q) sample, one micro-rotation per
// clock, with a start/busy/done handshake.
module cordic_vectoring #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned N_ITER = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic signed [WIDTH-1:0] i_x,
  input  logic signed [WIDTH-1:0] i_y,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [15:0]             o_angle,
  output logic [WIDTH:0]          o_mag
);

  // Two guard bits: one so -2^(WIDTH-1) negates cleanly, one for the CORDIC gain.
  localparam int unsigned DW = WIDTH + 2;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned MW = WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // atan(2^-i) in binary-angle units (65536 = full turn).
  function automatic logic [AW-1:0] atan_rom(input logic [CW-1:0] idx);
    logic [AW-1:0] a;
    case (idx)
      4'd0:    a = 16'd8192;
      4'd1:    a = 16'd4836;
      4'd2:    a = 16'd2555;
      4'd3:    a = 16'd1297;
      4'd4:    a = 16'd651;
      4'd5:    a = 16'd326;
      4'd6:    a = 16'd163;
      4'd7:    a = 16'd81;
      4'd8:    a = 16'd41;
      4'd9:    a = 16'd20;
      4'd10:   a = 16'd10;
      4'd11:   a = 16'd5;
      4'd12:   a = 16'd3;
      4'd13:   a = 16'd1;
      4'd14:   a = 16'd1;
      default: a = 16'd0;
    endcase
    return a;
  endfunction

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic signed [DW-1:0] x_q, x_d;
  logic signed [DW-1:0] y_q, y_d;
  logic [AW-1:0]        z_q, z_d;
  logic                 zero_q, zero_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [AW-1:0]        angle_q, angle_d;
  logic [MW-1:0]        mag_q, mag_d;

  logic signed [DW-1:0] ext_x_c;
  logic signed [DW-1:0] ext_y_c;
  logic signed [DW-1:0] x_sh_c;
  logic signed [DW-1:0] y_sh_c;
  logic [AW-1:0]        atan_c;

  // Sign-extended inputs and the shifted cross terms for the current stage.
  always_comb begin
    ext_x_c = DW'(i_x);
    ext_y_c = DW'(i_y);
    x_sh_c  = x_q >>> count_q;
    y_sh_c  = y_q >>> count_q;
    atan_c  = atan_rom(count_q);
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    angle_d = angle_q;
    mag_d   = mag_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          // Fold the left half-plane onto the right with a 180-degree pre-rotation.
          if (i_x < 0) begin
            x_d = -ext_x_c;
            y_d = -ext_y_c;
            z_d = 16'h8000;
          end else begin
            x_d = ext_x_c;
            y_d = ext_y_c;
            z_d = '0;
          end
          zero_d  = (i_x == '0) && (i_y == '0);
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_ITER;
        end
      end

      S_ITER: begin
        // Rotate toward the +x axis; z accumulates the angle swept.
        if (!y_q[DW-1]) begin
          x_d = x_q + y_sh_c;
          y_d = y_q - x_sh_c;
          z_d = z_q + atan_c;
        end else begin
          x_d = x_q - y_sh_c;
          y_d = y_q + x_sh_c;
          z_d = z_q - atan_c;
        end
        if (count_q == CW'(N_ITER - 1)) begin
          state_d = S_DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end

      S_DONE: begin
        // A zero vector would otherwise report the sum of ROM angles.
        angle_d = zero_q ? '0 : z_q;
        mag_d   = zero_q ? '0 : MW'(x_q[WIDTH:0]);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      angle_q <= '0;
      mag_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      angle_q <= angle_d;
      mag_q   <= mag_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_angle = angle_q;
  assign o_mag   = mag_q;

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring: reset, quadrants, extremes, zero/wrap,
// handshake and mid-transaction abort.
module tb_cordic_vectoring;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned N_ITER = 12;
  localparam int          LAT    = 13;
  localparam int          BOUND  = 60;

  logic                    clock;
  logic                    reset;
  logic                    i_start;
  logic signed [WIDTH-1:0] i_x;
  logic signed [WIDTH-1:0] i_y;
  logic                    o_busy;
  logic                    o_done;
  logic [15:0]             o_angle;
  logic [WIDTH:0]          o_mag;

  int n_checks = 0;
  int n_pass   = 0;

  cordic_vectoring #(.WIDTH(WIDTH), .N_ITER(N_ITER)) dut (
    .clock   (clock),
    .reset   (reset),
    .i_start (i_start),
    .i_x     (i_x),
    .i_y     (i_y),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_angle (o_angle),
    .o_mag   (o_mag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare observed against expected within tol; modular compares mod 2^16.
  task automatic check(input string tag, input int obs, input int exp,
                       input int tol, input bit modular);
    int d;
    d = obs - exp;
    if (modular) begin
      d = ((d % 65536) + 65536) % 65536;
      if (d > 32768) d = d - 65536;
    end
    if (d < 0) d = -d;
    n_checks++;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
  endtask

  function automatic int mag_tol(input int ideal);
    return 2 + (ideal + 999) / 1000;
  endfunction

  // Present a sample now (just after an edge); returns after the accepting edge.
  task automatic launch(input int x, input int y);
    i_x     = WIDTH'(x);
    i_y     = WIDTH'(y);
    i_start = 1'b1;
    @(posedge clock);
    #1;
    i_start = 1'b0;
  endtask

  // Count edges until o_done is seen; n includes the edge already passed.
  task automatic wait_done(input int start_n, output int n);
    n = start_n;
    while (!o_done && n < BOUND) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic run(input string tag, input int x, input int y,
                     input int exp_ang, input int exp_mag);
    int n;
    launch(x, y);
    check({tag, ".busy"}, int'(o_busy), 1, 0, 1'b0);
    wait_done(0, n);
    check({tag, ".lat"}, n, LAT, 0, 1'b0);
    check({tag, ".ang"}, int'(o_angle), exp_ang, 8, 1'b1);
    check({tag, ".mag"}, int'(o_mag), exp_mag, mag_tol(exp_mag), 1'b0);
    @(posedge clock);
    #1;
    check({tag, ".pulse"}, int'(o_done), 0, 0, 1'b0);
  endtask

  initial begin
    int n;
    int seen;
    reset   = 1'b0;
    i_start = 1'b1;
    i_x     = '0;
    i_y     = '0;

    // Reset held with start asserted.
    repeat (3) @(posedge clock);
    #1;
    check("rst.busy",  int'(o_busy),  0, 0, 1'b0);
    check("rst.done",  int'(o_done),  0, 0, 1'b0);
    check("rst.angle", int'(o_angle), 0, 0, 1'b0);
    check("rst.mag",   int'(o_mag),   0, 0, 1'b0);
    reset = 1'b1;
    run("first", 1000, 0, 0, 1647);

    // Quadrant sweep.
    run("q_90",  0,     1000,  16384, 1647);
    run("q_180", -1000, 0,     32768, 1647);
    run("q_270", 0,     -1000, 49152, 1647);
    run("q_45",  1000,  1000,  8192,  2329);
    run("q_225", -1000, -1000, 40960, 2329);

    // Extremes.
    run("ext_neg", -32768, -32768, 40960, 76314);
    run("ext_pos", 32767,  0,      0,     53959);

    // Zero vector is forced exactly; tiny negative angle wraps near 65535.
    launch(0, 0);
    wait_done(0, n);
    check("zero.lat", n, LAT, 0, 1'b0);
    check("zero.ang", int'(o_angle), 0, 0, 1'b0);
    check("zero.mag", int'(o_mag),   0, 0, 1'b0);
    @(posedge clock);
    #1;
    run("wrap", 1000, -1, 65526, 1647);

    // Start during ITER with different data is ignored.
    launch(0, 1000);
    repeat (3) @(posedge clock);
    #1;
    i_x = 16'sd1000;
    i_y = 16'sd1000;
    i_start = 1'b1;
    @(posedge clock);
    #1;
    i_start = 1'b0;
    wait_done(4, n);
    check("ign.lat", n, LAT, 0, 1'b0);
    check("ign.ang", int'(o_angle), 16384, 8, 1'b1);
    check("ign.mag", int'(o_mag), 1647, mag_tol(1647), 1'b0);
    @(posedge clock);
    #1;
    check("ign.nodup", int'(o_busy), 0, 0, 1'b0);

    // Back-to-back: start presented in the o_done cycle.
    launch(1000, 1000);
    wait_done(0, n);
    check("b2b.lat1", n, LAT, 0, 1'b0);
    launch(0, -1000);
    check("b2b.busy", int'(o_busy), 1, 0, 1'b0);
    wait_done(1, n);
    check("b2b.gap", n, LAT + 1, 0, 1'b0);
    check("b2b.ang", int'(o_angle), 49152, 8, 1'b1);
    check("b2b.mag", int'(o_mag), 1647, mag_tol(1647), 1'b0);
    @(posedge clock);
    #1;

    // Abort at iteration 5: outputs clear at once, no done pulse follows.
    launch(1000, 1000);
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("abort.busy",  int'(o_busy),  0, 0, 1'b0);
    check("abort.done",  int'(o_done),  0, 0, 1'b0);
    check("abort.angle", int'(o_angle), 0, 0, 1'b0);
    check("abort.mag",   int'(o_mag),   0, 0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (o_done) seen++;
    end
    check("abort.nodone", seen, 0, 0, 1'b0);
    run("after_abort", -1000, 0, 32768, 1647);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
